// File: rtl/ysyx_23060096_pkg.sv
// Shared encodings for the NPC write-back path: result-source select,
// load size and the WBU state machine.
package ysyx_23060096_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_B   = 2'b00,
        LD_H   = 2'b01,
        LD_W   = 2'b10,
        LD_RSV = 2'b11
    } ld_size_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_WAIT_MEM = 2'b01,
        S_COMMIT   = 2'b10
    } wbu_state_e;

    // Reserved size is treated as misaligned so it retires without a write.
    function automatic logic ld_misaligned(input ld_size_e size, input logic [1:0] offset);
        logic mis;
        case (size)
            LD_B:    mis = 1'b0;
            LD_H:    mis = offset[0];
            LD_W:    mis = (offset != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_23060096_load_align.sv
// Combinational load aligner: picks the byte/half/word out of a word-aligned
// response, then sign- or zero-extends it to XLEN.
module ysyx_23060096_load_align
    import ysyx_23060096_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  ld_size_e        size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;

    assign byte_v = rdata[{offset, 3'b000} +: 8];
    assign half_v = rdata[{offset[1], 4'b0000} +: 16];
    assign word_v = rdata[31:0];

    always_comb begin
        data = '0;
        case (size)
            LD_B:    data = is_unsigned ? XLEN'(byte_v) : XLEN'($signed(byte_v));
            LD_H:    data = is_unsigned ? XLEN'(half_v) : XLEN'($signed(half_v));
            LD_W:    data = is_unsigned ? XLEN'(word_v) : XLEN'($signed(word_v));
            default: data = '0;
        endcase
    end

    assign misalign = ld_misaligned(size, offset);

endmodule

// File: rtl/ysyx_23060096_wbu.sv
// Write-back unit: takes one retiring instruction, waits for load data when
// needed, then issues a single register-file write plus a commit pulse.
module ysyx_23060096_wbu
    import ysyx_23060096_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic [1:0]            in_wb_sel,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [1:0]            in_ld_size,
    input  logic                  in_ld_unsigned,

    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  mem_rready,

    output logic                  rf_w_en,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,

    output logic                  commit_valid,
    output logic [XLEN-1:0]       commit_pc,
    output logic                  misalign_err
);

    // Only what the load path needs after the accept edge is held here;
    // non-load results go straight into the commit registers on accept.
    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_wen;
        logic [1:0]            ld_off;
        ld_size_e              ld_size;
        logic                  ld_unsigned;
    } wb_req_t;

    wbu_state_e state, next_state;
    wb_req_t    req;
    wb_sel_e    in_sel;

    logic                  accept;
    logic                  rsp_fire;
    logic [XLEN-1:0]       ld_data;
    logic                  ld_mis;

    logic                  cmt_go;
    logic                  cmt_wen;
    logic                  cmt_mis;
    logic [REG_ADDR_W-1:0] cmt_rd;
    logic [XLEN-1:0]       cmt_data;
    logic [XLEN-1:0]       cmt_pc;

    assign in_sel   = wb_sel_e'(in_wb_sel);
    assign accept   = in_valid && (state == S_IDLE);
    assign rsp_fire = mem_rvalid && (state == S_WAIT_MEM);

    ysyx_23060096_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata      (mem_rdata),
        .offset     (req.ld_off),
        .size       (req.ld_size),
        .is_unsigned(req.ld_unsigned),
        .data       (ld_data),
        .misalign   (ld_mis)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) next_state = (in_sel == WB_LOAD) ? S_WAIT_MEM : S_COMMIT;
            end
            S_WAIT_MEM: begin
                if (rsp_fire) next_state = S_COMMIT;
            end
            S_COMMIT: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Staging for the commit registers: loaded on the edge that enters COMMIT.
    always_comb begin
        in_ready   = (state == S_IDLE);
        mem_rready = (state == S_WAIT_MEM);
        cmt_go     = 1'b0;
        cmt_wen    = 1'b0;
        cmt_mis    = 1'b0;
        cmt_rd     = req.rd;
        cmt_data   = ld_data;
        cmt_pc     = req.pc;
        case (state)
            S_IDLE: begin
                cmt_go   = accept && (in_sel != WB_LOAD);
                cmt_wen  = in_rd_wen && (in_sel != WB_NONE) && (in_rd != '0);
                cmt_rd   = in_rd;
                cmt_pc   = in_pc;
                cmt_data = (in_sel == WB_PC4) ? in_pc + XLEN'(4) : in_alu_result;
            end
            S_WAIT_MEM: begin
                cmt_go  = rsp_fire;
                cmt_wen = req.rd_wen && (req.rd != '0) && !ld_mis;
                cmt_mis = ld_mis;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req <= '0;
        end else if (accept) begin
            req.pc          <= in_pc;
            req.rd          <= in_rd;
            req.rd_wen      <= in_rd_wen;
            req.ld_off      <= in_alu_result[1:0];
            req.ld_size     <= ld_size_e'(in_ld_size);
            req.ld_unsigned <= in_ld_unsigned;
        end
    end

    // Pulses clear on the edge leaving COMMIT; address/data/pc hold until the next one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_w_en      <= 1'b0;
            commit_valid <= 1'b0;
            misalign_err <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            commit_pc    <= '0;
        end else begin
            rf_w_en      <= cmt_go && cmt_wen;
            commit_valid <= cmt_go;
            misalign_err <= cmt_go && cmt_mis;
            if (cmt_go) begin
                rf_waddr  <= cmt_rd;
                rf_wdata  <= cmt_data;
                commit_pc <= cmt_pc;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_wbu.sv
// Bench for the write-back unit: directed scenarios plus random instructions
// checked against an arithmetic reference model.
module tb_ysyx_23060096_wbu;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_rd = '0;
    logic        in_rd_wen = 1'b0;
    logic [1:0]  in_wb_sel = '0;
    logic [31:0] in_alu_result = '0;
    logic [1:0]  in_ld_size = '0;
    logic        in_ld_unsigned = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rready;
    logic        rf_w_en;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        misalign_err;

    int total = 0;
    int bad = 0;
    int cv_cnt = 0;
    int we_cnt = 0;

    ysyx_23060096_wbu dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
        .in_rd_wen(in_rd_wen), .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
        .rf_w_en(rf_w_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (commit_valid === 1'b1) cv_cnt++;
        if (rf_w_en === 1'b1) we_cnt++;
    end

    // Expected write data / write enable / misalign from the instruction's rules.
    function automatic void ref_model(input logic [31:0] pc, alu, rdata, input logic [4:0] rd,
                                      input logic wen, input logic [1:0] sel, size, input logic uns,
                                      output logic [31:0] d, output logic w, output logic m);
        int unsigned off, v, width;
        off = alu % 4;
        d = '0;
        m = 1'b0;
        if (sel == 2'd0) d = alu;
        else if (sel == 2'd2) d = pc + 32'd4;
        else if (sel == 2'd1) begin
            if (size == 2'd3 || (size == 2'd1 && off % 2 == 1) || (size == 2'd2 && off != 0)) m = 1'b1;
            else if (size == 2'd2) d = rdata;
            else begin
                width = (size == 2'd0) ? 8 : 16;
                v = (rdata >> (8 * off)) % (32'd1 << width);
                if (!uns && v >= (32'd1 << (width - 1))) v = v - (32'd1 << width);
                d = v;
            end
        end
        w = wen && (sel != 2'd3) && (rd != '0) && !m;
    endfunction

    // Drives one instruction from IDLE (called at posedge+1) and returns what
    // was observed in its COMMIT cycle and the cycle after.
    task automatic run_instr(input logic [31:0] pc, alu, rdata, input logic [4:0] rd,
                             input logic wen, input logic [1:0] sel, size, input logic uns, input int wt,
                             output logic o_wen, output logic [4:0] o_waddr, output logic [31:0] o_wdata,
                             output logic o_cv, output logic [31:0] o_pc, output logic o_mis,
                             output int o_rr, output logic o_rdy_commit, output logic o_rdy_after,
                             output logic o_cv_after);
        in_valid = 1'b1; in_pc = pc; in_alu_result = alu; in_rd = rd; in_rd_wen = wen;
        in_wb_sel = sel; in_ld_size = size; in_ld_unsigned = uns;
        @(posedge clk); #1;
        in_valid = 1'b0;
        o_rr = 0;
        if (sel == 2'b01) begin
            for (int i = 0; i < wt; i++) begin
                o_rr += int'(mem_rready);
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b1; mem_rdata = rdata;
            o_rr += int'(mem_rready);
            @(posedge clk); #1;
            mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
        o_wen = rf_w_en; o_waddr = rf_waddr; o_wdata = rf_wdata; o_cv = commit_valid;
        o_pc = commit_pc; o_mis = misalign_err; o_rdy_commit = in_ready;
        @(posedge clk); #1;
        o_rdy_after = in_ready; o_cv_after = commit_valid;
    endtask

    logic        g_wen, g_cv, g_mis, g_rc, g_ra, g_cva;
    logic [4:0]  g_waddr;
    logic [31:0] g_wdata, g_pc;
    int          g_rr;

    task automatic test_reset();
        rstn = 1'b0;
        #2;
        total++;
        if ({in_ready, mem_rready, rf_w_en, commit_valid, misalign_err} !== 5'b10000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=10000", {in_ready, mem_rready, rf_w_en, commit_valid, misalign_err});
        end
        total++;
        if ({rf_waddr, rf_wdata, commit_pc} !== '0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", rf_waddr, rf_wdata, commit_pc);
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        run_instr(32'h0000_1000, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 2'b00, 2'b00, 1'b0, 0,
                  g_wen, g_waddr, g_wdata, g_cv, g_pc, g_mis, g_rr, g_rc, g_ra, g_cva);
        total++;
        if ({g_wen, g_cv, g_mis, g_rc} !== 4'b1100) begin
            bad++; $display("FAIL alu_ctrl got=%b exp=1100", {g_wen, g_cv, g_mis, g_rc});
        end
        total++;
        if (g_waddr !== 5'd5 || g_wdata !== 32'h1234_5678 || g_pc !== 32'h0000_1000) begin
            bad++; $display("FAIL alu_data got=%0d/%h/%h exp=5/12345678/00001000", g_waddr, g_wdata, g_pc);
        end
        total++;
        if (g_ra !== 1'b1 || g_cva !== 1'b0) begin
            bad++; $display("FAIL alu_after got=%b%b exp=10", g_ra, g_cva);
        end
    endtask

    task automatic test_load_lb();
        run_instr(32'h0000_2000, 32'h8000_0003, 32'h80FF_FFFF, 5'd7, 1'b1, 2'b01, 2'b00, 1'b0, 4,
                  g_wen, g_waddr, g_wdata, g_cv, g_pc, g_mis, g_rr, g_rc, g_ra, g_cva);
        total++;
        if (g_wdata !== 32'hFFFF_FF80 || g_wen !== 1'b1 || g_cv !== 1'b1) begin
            bad++; $display("FAIL lb_data got=%h we=%b cv=%b exp=ffffff80 we=1 cv=1", g_wdata, g_wen, g_cv);
        end
        total++;
        if (g_rr != 5) begin
            bad++; $display("FAIL lb_rready_cycles got=%0d exp=5", g_rr);
        end
        total++;
        if (mem_rready !== 1'b0) begin
            bad++; $display("FAIL lb_rready_idle got=%b exp=0", mem_rready);
        end
    endtask

    task automatic test_load_half();
        run_instr(32'h0000_3000, 32'h0000_0102, 32'hBEEF_0000, 5'd9, 1'b1, 2'b01, 2'b01, 1'b1, 1,
                  g_wen, g_waddr, g_wdata, g_cv, g_pc, g_mis, g_rr, g_rc, g_ra, g_cva);
        total++;
        if (g_wdata !== 32'h0000_BEEF || g_wen !== 1'b1 || g_mis !== 1'b0) begin
            bad++; $display("FAIL lhu_data got=%h we=%b mis=%b exp=0000beef we=1 mis=0", g_wdata, g_wen, g_mis);
        end
        run_instr(32'h0000_3004, 32'h0000_0101, 32'hBEEF_0000, 5'd9, 1'b1, 2'b01, 2'b01, 1'b0, 0,
                  g_wen, g_waddr, g_wdata, g_cv, g_pc, g_mis, g_rr, g_rc, g_ra, g_cva);
        total++;
        if ({g_mis, g_wen, g_cv} !== 3'b101 || g_pc !== 32'h0000_3004) begin
            bad++; $display("FAIL lh_misalign got=%b pc=%h exp=101 pc=00003004", {g_mis, g_wen, g_cv}, g_pc);
        end
        total++;
        if (misalign_err !== 1'b0) begin
            bad++; $display("FAIL lh_misalign_pulse got=%b exp=0", misalign_err);
        end
    endtask

    task automatic test_pc4();
        run_instr(32'hFFFF_FFFC, 32'h0, 32'h0, 5'd1, 1'b1, 2'b10, 2'b00, 1'b0, 0,
                  g_wen, g_waddr, g_wdata, g_cv, g_pc, g_mis, g_rr, g_rc, g_ra, g_cva);
        total++;
        if (g_wdata !== 32'h0 || g_wen !== 1'b1 || g_waddr !== 5'd1) begin
            bad++; $display("FAIL pc4_wrap got=%h we=%b a=%0d exp=00000000 we=1 a=1", g_wdata, g_wen, g_waddr);
        end
        run_instr(32'hFFFF_FFFC, 32'h0, 32'h0, 5'd0, 1'b1, 2'b10, 2'b00, 1'b0, 0,
                  g_wen, g_waddr, g_wdata, g_cv, g_pc, g_mis, g_rr, g_rc, g_ra, g_cva);
        total++;
        if ({g_wen, g_cv} !== 2'b01) begin
            bad++; $display("FAIL pc4_rd0 got=%b exp=01", {g_wen, g_cv});
        end
    endtask

    task automatic test_stray_rvalid();
        int c0;
        total++;
        if (mem_rready !== 1'b0) begin
            bad++; $display("FAIL stray_rready got=%b exp=0", mem_rready);
        end
        c0 = cv_cnt;
        mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (cv_cnt != c0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL stray_ignored got=%0d rdy=%b exp=%0d rdy=1", cv_cnt, in_ready, c0);
        end
        run_instr(32'h0000_4000, 32'h0000_0000, 32'h1357_9BDF, 5'd12, 1'b1, 2'b01, 2'b10, 1'b0, 2,
                  g_wen, g_waddr, g_wdata, g_cv, g_pc, g_mis, g_rr, g_rc, g_ra, g_cva);
        total++;
        if (g_wdata !== 32'h1357_9BDF || g_rr != 3 || cv_cnt != c0 + 1) begin
            bad++; $display("FAIL stray_fresh got=%h rr=%0d cv=%0d exp=13579bdf rr=3 cv=%0d", g_wdata, g_rr, cv_cnt, c0 + 1);
        end
    endtask

    task automatic test_reset_mid_wait();
        int c0, w0;
        c0 = cv_cnt; w0 = we_cnt;
        in_valid = 1'b1; in_pc = 32'h0000_5000; in_alu_result = 32'h0; in_rd = 5'd3;
        in_rd_wen = 1'b1; in_wb_sel = 2'b01; in_ld_size = 2'b10; in_ld_unsigned = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (mem_rready !== 1'b1) begin
            bad++; $display("FAIL rst_wait_rready got=%b exp=1", mem_rready);
        end
        rstn = 1'b0;
        #1;
        total++;
        if ({in_ready, mem_rready, rf_wdata, commit_pc} !== {2'b10, 64'h0}) begin
            bad++; $display("FAIL rst_mid_outputs got=%b%b %h %h exp=10 0 0", in_ready, mem_rready, rf_wdata, commit_pc);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rstn = 1'b1; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (cv_cnt != c0 || we_cnt != w0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_dropped got=cv%0d we%0d rdy%b exp=cv%0d we%0d rdy1", cv_cnt, we_cnt, in_ready, c0, w0);
        end
        run_instr(32'h0000_6000, 32'hCAFE_0001, 32'h0, 5'd31, 1'b1, 2'b00, 2'b00, 1'b0, 0,
                  g_wen, g_waddr, g_wdata, g_cv, g_pc, g_mis, g_rr, g_rc, g_ra, g_cva);
        total++;
        if ({g_wen, g_cv} !== 2'b11 || g_wdata !== 32'hCAFE_0001 || g_waddr !== 5'd31) begin
            bad++; $display("FAIL rst_next got=%b %h %0d exp=11 cafe0001 31", {g_wen, g_cv}, g_wdata, g_waddr);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_pc = 32'h100; in_alu_result = 32'hAAAA_0001; in_rd = 5'd3;
        in_rd_wen = 1'b1; in_wb_sel = 2'b00;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b0 || rf_wdata !== 32'hAAAA_0001 || commit_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_first got=rdy%b %h cv%b exp=rdy0 aaaa0001 cv1", in_ready, rf_wdata, commit_valid);
        end
        in_pc = 32'h104; in_alu_result = 32'hBBBB_0002; in_rd = 5'd4;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || commit_valid !== 1'b0 || rf_wdata !== 32'hAAAA_0001) begin
            bad++; $display("FAIL b2b_gap got=rdy%b cv%b %h exp=rdy1 cv0 aaaa0001", in_ready, commit_valid, rf_wdata);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (commit_valid !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hBBBB_0002 || commit_pc !== 32'h104) begin
            bad++; $display("FAIL b2b_second got=cv%b %0d %h %h exp=cv1 4 bbbb0002 00000104", commit_valid, rf_waddr, rf_wdata, commit_pc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] pc, alu, rdata, ed;
        logic [4:0]  rd;
        logic [1:0]  sel, size;
        logic        wen, uns, ew, em;
        int          wt, c0;
        for (int n = 0; n < 150; n++) begin
            pc = $urandom; alu = $urandom; rdata = $urandom;
            rd = 5'($urandom_range(0, 31)); wen = ($urandom_range(0, 3) != 0);
            sel = 2'($urandom_range(0, 3)); size = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1)); wt = $urandom_range(0, 3);
            ref_model(pc, alu, rdata, rd, wen, sel, size, uns, ed, ew, em);
            c0 = cv_cnt;
            run_instr(pc, alu, rdata, rd, wen, sel, size, uns, wt,
                      g_wen, g_waddr, g_wdata, g_cv, g_pc, g_mis, g_rr, g_rc, g_ra, g_cva);
            total++;
            if (g_wen !== ew || g_mis !== em || g_cv !== 1'b1 || g_waddr !== rd || g_pc !== pc) begin
                bad++; $display("FAIL rand_ctrl n=%0d got=we%b mis%b cv%b a%0d pc%h exp=we%b mis%b cv1 a%0d pc%h",
                                n, g_wen, g_mis, g_cv, g_waddr, g_pc, ew, em, rd, pc);
            end
            if (ew) begin
                total++;
                if (g_wdata !== ed) begin
                    bad++; $display("FAIL rand_wdata n=%0d sel=%0d size=%0d got=%h exp=%h", n, sel, size, g_wdata, ed);
                end
            end
            total++;
            if (cv_cnt != c0 + 1 || g_rc !== 1'b0 || g_ra !== 1'b1 || g_cva !== 1'b0) begin
                bad++; $display("FAIL rand_pulse n=%0d got=cnt%0d rc%b ra%b cva%b exp=cnt%0d rc0 ra1 cva0",
                                n, cv_cnt - c0, g_rc, g_ra, g_cva, 1);
            end
            if (sel == 2'b01) begin
                total++;
                if (g_rr != wt + 1) begin
                    bad++; $display("FAIL rand_rready n=%0d got=%0d exp=%0d", n, g_rr, wt + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_lb();
        test_load_half();
        test_pc4();
        test_stray_rvalid();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
